adc_scan_ctrl: RTL and testbench

// - Parametrised serial-ADC controller (MCP300x-style SPI, mode 0,0); multi-channel successor to the single-channel 8-bit ADC front end.
// - Generates cs_n/sclk/din, shifts in conversions, scans NUM_CH channels once or continuously.
// - Presents each result with channel tag and valid pulse; drives one threshold LED per channel.

---
 rtl/adc_scan_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_ctrl.sv
// Serial ADC scan controller (MCP300x-style SPI, mode 0,0): NUM_CH channels, once or continuously; optional led hysteresis under ADC_HYST_EN.
// Latency: one frame of SCLK_DIV + (3+CH_W+DATA_W)*2*SCLK_DIV + 2*SCLK_DIV clk per channel; data_valid one clk after the last data sample.
// Backpressure: none; results are overwritten by the next frame, and start is ignored while busy.
module adc_scan_ctrl #(
    parameter int DATA_W   = 8,
    parameter int NUM_CH   = 4,
    parameter int CH_W     = 2,
    parameter int SCLK_DIV = 4,
    parameter int HYST     = 2
) (
    input  logic              clk,
    input  logic              rstc_n,
    input  logic              start,
    input  logic              cont,
    input  logic [DATA_W-1:0] thresh,
    input  logic              doutb,
    output logic              cs_n,
    output logic              sclk,
    output logic              din,
    output logic [DATA_W-1:0] data_out,
    output logic [CH_W-1:0]   data_ch,
    output logic              data_valid,
    output logic              busy,
    output logic [NUM_CH-1:0] led
);

    localparam int CMD_W = 2 + CH_W;
    localparam int DIV_W = $clog2(2 * SCLK_DIV);
    localparam int BIT_W = $clog2((CMD_W > DATA_W) ? CMD_W : DATA_W);

    if (SCLK_DIV < 2 || NUM_CH < 1 || NUM_CH > 8 || DATA_W < 2 || HYST < 0 ||
        CH_W < $clog2(NUM_CH)) begin : g_bad_param
        $error("adc_scan_ctrl: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CMD,
        NUL,
        DATA,
        HOLD
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [CH_W-1:0]   chan;
    logic [CMD_W-1:0]  cmd_sr;
    logic [DATA_W-1:0] shreg;

    logic              half_end;
    logic              hold_end;
    logic              last_ch;
    logic [CH_W-1:0]   next_chan;
    logic [DATA_W-1:0] result_nxt;
    logic [NUM_CH-1:0] led_nxt;

    assign half_end   = (div_cnt == DIV_W'(SCLK_DIV - 1));
    assign hold_end   = (div_cnt == DIV_W'(2 * SCLK_DIV - 1));
    assign last_ch    = (chan == CH_W'(NUM_CH - 1));
    assign next_chan  = last_ch ? '0 : chan + CH_W'(1);
    assign result_nxt = {shreg[DATA_W-2:0], doutb};

`ifdef ADC_HYST_EN
    logic [DATA_W:0]   th_sum;
    logic [DATA_W-1:0] th_hi;
    logic [DATA_W-1:0] th_lo;

    assign th_sum = {1'b0, thresh} + (DATA_W + 1)'(HYST);
    assign th_hi  = th_sum[DATA_W] ? '1 : th_sum[DATA_W-1:0];
    assign th_lo  = (thresh >= DATA_W'(HYST)) ? thresh - DATA_W'(HYST) : '0;

    always_comb begin
        led_nxt = led;
        for (int i = 0; i < NUM_CH; i++) begin
            if (chan == CH_W'(i)) begin
                if (result_nxt > th_hi)
                    led_nxt[i] = 1'b1;
                else if (result_nxt < th_lo)
                    led_nxt[i] = 1'b0;
            end
        end
    end
`else
    always_comb begin
        led_nxt = led;
        for (int i = 0; i < NUM_CH; i++) begin
            if (chan == CH_W'(i))
                led_nxt[i] = (result_nxt > thresh);
        end
    end
`endif

    always_ff @(posedge clk or negedge rstc_n) begin
        if (!rstc_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            chan       <= '0;
            cmd_sr     <= '0;
            shreg      <= '0;
            cs_n       <= 1'b1;
            sclk       <= 1'b0;
            din        <= 1'b0;
            data_out   <= '0;
            data_ch    <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            led        <= '0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SETUP;
                        busy    <= 1'b1;
                        cs_n    <= 1'b0;
                        din     <= 1'b1;
                        chan    <= '0;
                        cmd_sr  <= {1'b1, {CH_W{1'b0}}, 1'b0};
                        div_cnt <= '0;
                    end
                end
                SETUP: begin
                    if (half_end) begin
                        state   <= CMD;
                        sclk    <= 1'b1;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                CMD, NUL, DATA: begin
                    if (!half_end) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (sclk) begin
                            // Falling edge: next command bit, zeros once the command is out.
                            sclk   <= 1'b0;
                            din    <= cmd_sr[CMD_W-1];
                            cmd_sr <= {cmd_sr[CMD_W-2:0], 1'b0};
                        end else if (state == CMD) begin
                            sclk <= 1'b1;
                            if (bit_cnt == BIT_W'(CMD_W - 1)) begin
                                state   <= NUL;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end else if (state == NUL) begin
                            sclk    <= 1'b1;
                            state   <= DATA;
                            bit_cnt <= '0;
                            shreg   <= result_nxt;
                        end else if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                            state <= HOLD;
                            cs_n  <= 1'b1;
                        end else begin
                            sclk    <= 1'b1;
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            shreg   <= result_nxt;
                            if (bit_cnt == BIT_W'(DATA_W - 2)) begin
                                data_out   <= result_nxt;
                                data_ch    <= chan;
                                data_valid <= 1'b1;
                                led        <= led_nxt;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!hold_end) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        chan    <= next_chan;
                        if (!last_ch || cont) begin
                            state  <= SETUP;
                            cs_n   <= 1'b0;
                            din    <= 1'b1;
                            cmd_sr <= {1'b1, next_chan, 1'b0};
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Scoreboard bench for adc_scan_ctrl with a behavioural MCP300x model on the serial pins.
`timescale 1ns/1ps
module tb_adc_scan_ctrl;

    localparam int DW    = 8;
    localparam int NC    = 4;
    localparam int CW    = 2;
    localparam int SD    = 4;
    localparam int CMD_W = 2 + CW;
    localparam int FRAME = 116;
    localparam int FIRST = 100;

    typedef struct {
        logic [DW-1:0] dat;
        logic [CW-1:0] ch;
        logic [NC-1:0] led;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstc_n;
    logic          start;
    logic          cont;
    logic [DW-1:0] thresh;
    logic          doutb = 1'b0;
    logic          cs_n;
    logic          sclk;
    logic          din;
    logic [DW-1:0] data_out;
    logic [CW-1:0] data_ch;
    logic          data_valid;
    logic          busy;
    logic [NC-1:0] led;

    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;
    exp_t          exp_q[$];
    int            cmd_q[$];
    exp_t          mon_e;
    logic [DW-1:0] adc_val [NC];
    logic [NC-1:0] model_led;

    adc_scan_ctrl #(.DATA_W(DW), .NUM_CH(NC), .CH_W(CW), .SCLK_DIV(SD), .HYST(2)) dut (
        .clk(clk), .rstc_n(rstc_n), .start(start), .cont(cont), .thresh(thresh),
        .doutb(doutb), .cs_n(cs_n), .sclk(sclk), .din(din), .data_out(data_out),
        .data_ch(data_ch), .data_valid(data_valid), .busy(busy), .led(led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural ADC: captures the command on sclk rising, shifts null + result out on falling.
    logic             sclk_q = 1'b0;
    int               n_rise = 0;
    int               n_fall = 0;
    logic [CMD_W-1:0] cmd_cap = '0;
    logic [DW-1:0]    cur_val = '0;
    int               exp_ch;

    always @(negedge clk) begin
        sclk_q <= sclk;
        if (cs_n) begin
            n_rise <= 0;
            n_fall <= 0;
        end else begin
            if (sclk && !sclk_q) begin
                if (n_rise < CMD_W) cmd_cap <= {cmd_cap[CMD_W-2:0], din};
                n_rise <= n_rise + 1;
            end
            if (!sclk && sclk_q) begin
                n_fall <= n_fall + 1;
                if (n_fall + 1 == CMD_W) begin
                    if (cmd_q.size() == 0) begin
                        chk("cmd_unexpected", 32'(cmd_cap), 32'hFFFF_FFFF);
                    end else begin
                        exp_ch = cmd_q.pop_front();
                        chk("cmd_word", 32'(cmd_cap), 32'({2'b11, exp_ch[CW-1:0]}));
                    end
                    cur_val <= adc_val[cmd_cap[CW-1:0]];
                    doutb   <= 1'b0;
                end else if (n_fall + 1 > CMD_W) begin
                    doutb   <= cur_val[DW-1];
                    cur_val <= {cur_val[DW-2:0], 1'b0};
                end
            end
        end
    end

    always @(negedge clk) begin
        if (data_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(data_ch), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("data_out", 32'(data_out), 32'(mon_e.dat));
                chk("data_ch", 32'(data_ch), 32'(mon_e.ch));
                chk("led", 32'(led), 32'(mon_e.led));
                chk("valid_cyc", cyc, mon_e.cyc);
            end
        end
    end

    task automatic push_frames(input int s, input int n);
        for (int k = 0; k < n; k++) begin
            int   ch;
            int   hi;
            int   lo;
            exp_t e;
            ch = k % NC;
            hi = int'(thresh) + 2;
            lo = int'(thresh) - 2;
            if (hi > 255) hi = 255;
            if (lo < 0) lo = 0;
`ifdef ADC_HYST_EN
            if (int'(adc_val[ch]) > hi) model_led[ch] = 1'b1;
            else if (int'(adc_val[ch]) < lo) model_led[ch] = 1'b0;
`else
            model_led[ch] = (adc_val[ch] > thresh);
`endif
            e.dat = adc_val[ch];
            e.ch  = CW'(ch);
            e.led = model_led;
            e.cyc = s + FIRST + FRAME * k;
            exp_q.push_back(e);
            cmd_q.push_back(ch);
        end
    endtask

    task automatic do_start(output int s);
        @(negedge clk);
        start = 1'b1;
        s     = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_idle(input int s, input int n);
        int lim;
        lim = 0;
        while (busy && lim < FRAME * n + 50) begin
            @(negedge clk);
            lim++;
        end
        chk("busy_fall_cyc", cyc, s + FRAME * n);
    endtask

    task automatic run_scan(input logic c, input int n, input bit pulse);
        int s;
        cont = c;
        do_start(s);
        push_frames(s, n);
        if (pulse) begin
            for (int k = 0; k < n; k++) begin
                wait_until(s + FRAME * k + 58);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        wait_idle(s, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int s;
        int hv   [5];
        int hexp [5];
        hv   = '{103, 101, 99, 97, 99};
        hexp = '{1, 1, 1, 0, 0};
        rstc_n    = 1'b0;
        start     = 1'b0;
        cont      = 1'b0;
        thresh    = '0;
        model_led = '0;
        for (int i = 0; i < NC; i++) adc_val[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_din", 32'(din), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_data_ch", 32'(data_ch), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        rstc_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single pass, constant A5 on every channel.
        thresh = 8'h80;
        for (int i = 0; i < NC; i++) adc_val[i] = 8'hA5;
        run_scan(1'b0, NC, 1'b0);
        chk("scan1_led", 32'(led), 32'hF);

        // Start pulses mid-frame while busy must be ignored.
        thresh  = 8'h20;
        adc_val = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_scan(1'b0, NC, 1'b1);
        chk("ignored_led", 32'(led), 32'hE);

        // Threshold boundaries: above, equal, zero, all-ones.
        thresh  = 8'd7;
        adc_val = '{8'd8, 8'd7, 8'd0, 8'hFF};
        run_scan(1'b0, NC, 1'b0);
`ifndef ADC_HYST_EN
        chk("thresh_led", 32'(led), 32'b1001);
`endif

        // Continuous: two passes, cont dropped during ch1 of the second pass.
        thresh  = 8'h40;
        adc_val = '{8'h3F, 8'h40, 8'h41, 8'hC3};
        cont    = 1'b1;
        do_start(s);
        push_frames(s, 2 * NC);
        wait_until(s + FRAME * (NC + 1) + 50);
        cont = 1'b0;
        wait_idle(s, 2 * NC);
        repeat (FRAME + 10) @(negedge clk);
        chk("cont_busy_idle", 32'(busy), 32'd0);

        // Reset during DATA bit 4 of channel 0.
        adc_val = '{8'h5A, 8'h00, 8'h81, 8'h7E};
        cont    = 1'b0;
        do_start(s);
        cmd_q.push_back(0);
        wait_until(s + 78);
        rstc_n = 1'b0;
        #1;
        chk("mid_rst_cs_n", 32'(cs_n), 32'd1);
        chk("mid_rst_sclk", 32'(sclk), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(data_valid), 32'd0);
        repeat (2) @(negedge clk);
        rstc_n    = 1'b1;
        model_led = '0;
        repeat (40) @(negedge clk);
        chk("post_rst_data_out", 32'(data_out), 32'd0);
        chk("post_rst_led", 32'(led), 32'd0);
        thresh = 8'h10;
        run_scan(1'b0, NC, 1'b0);

`ifdef ADC_HYST_EN
        thresh = 8'd100;
        for (int i = 0; i < NC; i++) adc_val[i] = 8'd0;
        for (int k = 0; k < 5; k++) begin
            adc_val[0] = DW'(hv[k]);
            run_scan(1'b0, NC, 1'b0);
            chk("hyst_led0", 32'(led[0]), 32'(hexp[k]));
        end
`endif

        repeat (20) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("cmd_q_drained", cmd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
